// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and branch-condition encodings, default widths,
// and opcode-class helpers used by the execute/writeback flag stage.
package cpu_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_AW   = 4;
    localparam int DEF_NUM_COND = 8;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b010;
    localparam logic [2:0] SLL = 3'b011;
    localparam logic [2:0] SRL = 3'b100;
    localparam logic [2:0] SRA = 3'b101;
    localparam logic [2:0] LL  = 3'b110;
    localparam logic [2:0] LH  = 3'b111;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OVF    = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    typedef struct packed {
        logic z;
        logic ov;
        logic n;
    } flags_t;

    // Arithmetic ops own the overflow flag; everything except the loads owns Z/N.
    function automatic logic op_sets_ov(input logic [2:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

    function automatic logic op_sets_zn(input logic [2:0] op);
        return (op != LL) && (op != LH);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational branch-condition evaluator over a Z/OV/N flag triple.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic       z,
    input  logic       ov,
    input  logic       n,
    input  logic [2:0] cond,
    output logic       taken
);

    logic w_lt;

    assign w_lt = n ^ ov;

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~w_lt;
            COND_LT:     taken = w_lt;
            COND_GE:     taken = ~w_lt;
            COND_LE:     taken = z | w_lt;
            COND_OVF:    taken = ov;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-to-writeback pipeline register with architectural Z/OV/N flags and branch decision.
// Optional EX_FLAG_BYPASS_EN: branch evaluates the next-state flags instead of the held ones.
module ex_flag_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_COND = DEF_NUM_COND
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [2:0]                  in_opcode,
    input  logic [DATA_W-1:0]           in_result,
    input  logic                        in_z,
    input  logic                        in_ov,
    input  logic                        in_n,
    input  logic                        in_wr_en,
    input  logic [REG_AW-1:0]           in_dst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        clr_sticky,
    input  logic [$clog2(NUM_COND)-1:0] br_cond,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_result,
    output logic                        out_wr_en,
    output logic [REG_AW-1:0]           out_dst,
    output logic                        flag_z,
    output logic                        flag_ov,
    output logic                        flag_n,
    output logic                        ov_sticky,
    output logic                        br_taken
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_wr_en;
    logic [REG_AW-1:0] r_dst;
    flags_t            r_flags;
    logic              r_ov_sticky;

    logic   w_accept;
    logic   w_sticky_set;
    flags_t w_flags_next;
    flags_t w_br_flags;

    assign w_accept     = in_valid & ~stall & ~flush;
    assign w_sticky_set = w_accept & op_sets_ov(in_opcode) & in_ov;

    always_comb begin
        w_flags_next = r_flags;
        if (w_accept && op_sets_zn(in_opcode)) begin
            w_flags_next.z = in_z;
            w_flags_next.n = in_n;
        end
        if (w_accept && op_sets_ov(in_opcode)) begin
            w_flags_next.ov = in_ov;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_wr_en     <= 1'b0;
            r_dst       <= '0;
            r_flags     <= '0;
            r_ov_sticky <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            // Set has priority over a same-cycle clear.
            if (w_sticky_set) begin
                r_ov_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_ov_sticky <= 1'b0;
            end
            if (flush) begin
                r_valid <= 1'b0;
                r_wr_en <= 1'b0;
            end else if (!stall) begin
                r_valid  <= in_valid;
                r_result <= in_result;
                r_dst    <= in_dst;
                r_wr_en  <= in_valid & in_wr_en & (in_dst != '0);
            end
        end
    end

`ifdef EX_FLAG_BYPASS_EN
    assign w_br_flags = w_flags_next;
`else
    assign w_br_flags = r_flags;
`endif

    branch_cond_eval u_branch_cond_eval (
        .z     (w_br_flags.z),
        .ov    (w_br_flags.ov),
        .n     (w_br_flags.n),
        .cond  (br_cond[2:0]),
        .taken (br_taken)
    );

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_wr_en  = r_wr_en;
    assign out_dst    = r_dst;
    assign flag_z     = r_flags.z;
    assign flag_ov    = r_flags.ov;
    assign flag_n     = r_flags.n;
    assign ov_sticky  = r_ov_sticky;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed vector table, bypass sequence, random vs model.
module tb_ex_flag_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_z, in_ov, in_n, in_wr_en, stall, flush, clr_sticky;
    logic [2:0]  in_opcode, br_cond;
    logic [15:0] in_result;
    logic [3:0]  in_dst;
    logic        out_valid, out_wr_en, flag_z, flag_ov, flag_n, ov_sticky, br_taken;
    logic [15:0] out_result;
    logic [3:0]  out_dst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_flag_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_z       (in_z),
        .in_ov      (in_ov),
        .in_n       (in_n),
        .in_wr_en   (in_wr_en),
        .in_dst     (in_dst),
        .stall      (stall),
        .flush      (flush),
        .clr_sticky (clr_sticky),
        .br_cond    (br_cond),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_wr_en  (out_wr_en),
        .out_dst    (out_dst),
        .flag_z     (flag_z),
        .flag_ov    (flag_ov),
        .flag_n     (flag_n),
        .ov_sticky  (ov_sticky),
        .br_taken   (br_taken)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic z, input logic ov, input logic n,
                                     input logic [2:0] c);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && (n == ov);
            3'd3:    return n != ov;
            3'd4:    return n == ov;
            3'd5:    return z || (n != ov);
            3'd6:    return ov;
            default: return 1'b1;
        endcase
    endfunction

    typedef struct {
        logic rst; logic valid; logic [2:0] op; logic [15:0] res;
        logic z; logic ov; logic n; logic wr; logic [3:0] dst;
        logic stall; logic flush; logic clr; logic [2:0] cond;
        logic e_valid; logic e_wr; logic chk_data; logic [15:0] e_res; logic [3:0] e_dst;
        logic e_z; logic e_ov; logic e_n; logic e_sticky; logic e_br;
    } vec_t;

    vec_t vecs[$];

    task automatic idle_inputs();
        rst = 0; in_valid = 0; in_opcode = ADD; in_result = '0; in_z = 0; in_ov = 0; in_n = 0;
        in_wr_en = 0; in_dst = '0; stall = 0; flush = 0; clr_sticky = 0;
    endtask

    // Behavioural reference state
    logic        m_valid, m_wr, m_z, m_ov, m_n, m_sticky;
    logic [15:0] m_result;
    logic [3:0]  m_dst;

    function automatic logic is_arith(input logic [2:0] op); return op <= 3'd1; endfunction
    function automatic logic is_zn(input logic [2:0] op);    return op <= 3'd5; endfunction

    task automatic model_clock();
        logic take;
        take = in_valid && !stall && !flush;
        if (rst) begin
            {m_valid, m_wr, m_z, m_ov, m_n, m_sticky} = '0;
            m_result = '0; m_dst = '0;
        end else begin
            if (take && is_arith(in_opcode) && in_ov) m_sticky = 1;
            else if (clr_sticky) m_sticky = 0;
            if (take && is_zn(in_opcode)) begin m_z = in_z; m_n = in_n; end
            if (take && is_arith(in_opcode)) m_ov = in_ov;
            if (flush) begin
                m_valid = 0; m_wr = 0;
            end else if (!stall) begin
                m_valid = in_valid; m_result = in_result; m_dst = in_dst;
                m_wr = in_valid && in_wr_en && (in_dst != 0);
            end
        end
    endtask

    function automatic logic model_br();
        logic z, ov, n, take;
        z = m_z; ov = m_ov; n = m_n;
`ifdef EX_FLAG_BYPASS_EN
        take = in_valid && !stall && !flush;
        if (take && is_zn(in_opcode)) begin z = in_z; n = in_n; end
        if (take && is_arith(in_opcode)) ov = in_ov;
`else
        take = 1'b0;
`endif
        return cond_ok(z, ov, n, br_cond) | (take & 1'b0);
    endfunction

    initial begin
        idle_inputs();
        br_cond = COND_NE;

        // rst valid op res z ov n wr dst stall flush clr cond | valid wr chk res dst z ov n sticky br
        vecs.push_back('{1,1,ADD,16'hFFFF,1,1,1,1,4'h3,0,0,0,COND_NE, 0,0,1,16'h0000,4'h0,0,0,0,0,1});
        vecs.push_back('{0,0,ADD,16'h0000,0,0,0,0,4'h0,0,0,0,COND_EQ, 0,0,1,16'h0000,4'h0,0,0,0,0,0});
        vecs.push_back('{0,1,ADD,16'h8000,0,1,1,1,4'h3,0,0,0,COND_LT, 1,1,1,16'h8000,4'h3,0,1,1,1,0});
        vecs.push_back('{0,0,ADD,16'h0000,0,0,0,0,4'h0,0,0,0,COND_GE, 0,0,1,16'h0000,4'h0,0,1,1,1,1});
        vecs.push_back('{0,0,ADD,16'h0000,0,0,0,0,4'h0,0,0,1,COND_OVF,0,0,1,16'h0000,4'h0,0,1,1,0,1});
        vecs.push_back('{0,1,SUB,16'h0000,1,0,0,1,4'h2,0,0,0,COND_EQ, 1,1,1,16'h0000,4'h2,1,0,0,0,1});
        vecs.push_back('{0,1,LH ,16'h1200,0,1,1,1,4'h7,0,0,0,COND_EQ, 1,1,1,16'h1200,4'h7,1,0,0,0,1});
        vecs.push_back('{0,1,XOR,16'h8001,0,1,1,1,4'h4,0,0,0,COND_LT, 1,1,1,16'h8001,4'h4,0,0,1,0,1});
        vecs.push_back('{0,1,ADD,16'hAAAA,1,1,0,1,4'h9,1,0,0,COND_LT, 1,1,1,16'h8001,4'h4,0,0,1,0,1});
        vecs.push_back('{0,1,SUB,16'h1111,1,0,0,1,4'hA,1,0,0,COND_LT, 1,1,1,16'h8001,4'h4,0,0,1,0,1});
        vecs.push_back('{0,0,SLL,16'h2222,1,0,0,0,4'hB,1,0,0,COND_LT, 1,1,1,16'h8001,4'h4,0,0,1,0,1});
        vecs.push_back('{0,1,ADD,16'h3333,1,0,0,1,4'h6,1,1,0,COND_EQ, 0,0,0,16'h0000,4'h0,0,0,1,0,0});
        vecs.push_back('{0,1,LL ,16'h00AA,1,1,1,1,4'h0,0,0,0,COND_NE, 1,0,1,16'h00AA,4'h0,0,0,1,0,1});
        vecs.push_back('{0,1,LL ,16'h0055,0,0,0,1,4'h5,0,0,0,COND_NE, 1,1,1,16'h0055,4'h5,0,0,1,0,1});
        vecs.push_back('{0,1,SUB,16'h7FFF,0,1,0,1,4'h1,0,0,1,COND_GT, 1,1,1,16'h7FFF,4'h1,0,1,0,1,0});
        vecs.push_back('{0,1,SRA,16'hFFFE,0,0,1,0,4'h8,0,0,0,COND_LE, 1,0,1,16'hFFFE,4'h8,0,1,1,1,0});
        vecs.push_back('{0,1,SRL,16'h0001,1,0,0,1,4'h3,0,1,0,COND_UNCOND,0,0,0,16'h0,4'h0,0,1,1,1,1});
        vecs.push_back('{0,1,ADD,16'h0001,1,1,0,1,4'h3,0,1,1,COND_NE, 0,0,0,16'h0000,4'h0,0,1,1,0,1});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].valid; in_opcode = vecs[i].op;
            in_result = vecs[i].res; in_z = vecs[i].z; in_ov = vecs[i].ov; in_n = vecs[i].n;
            in_wr_en = vecs[i].wr; in_dst = vecs[i].dst; stall = vecs[i].stall;
            flush = vecs[i].flush; clr_sticky = vecs[i].clr; br_cond = vecs[i].cond;
            @(posedge clk);
            #1 idle_inputs();
            #1;
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d out_wr_en", i), out_wr_en, vecs[i].e_wr);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d out_result", i), out_result, vecs[i].e_res);
                check($sformatf("vec%0d out_dst", i), out_dst, vecs[i].e_dst);
            end
            check($sformatf("vec%0d flag_z", i), flag_z, vecs[i].e_z);
            check($sformatf("vec%0d flag_ov", i), flag_ov, vecs[i].e_ov);
            check($sformatf("vec%0d flag_n", i), flag_n, vecs[i].e_n);
            check($sformatf("vec%0d ov_sticky", i), ov_sticky, vecs[i].e_sticky);
            check($sformatf("vec%0d br_taken", i), br_taken, vecs[i].e_br);
        end

        // Compare-then-branch: same-cycle decision depends on the bypass build option.
        @(negedge clk); idle_inputs(); rst = 1;
        @(negedge clk); idle_inputs();
        in_valid = 1; in_opcode = SUB; in_z = 1; br_cond = COND_EQ;
        #1;
`ifdef EX_FLAG_BYPASS_EN
        check("bypass same-cycle EQ", br_taken, 1'b1);
`else
        check("held same-cycle EQ", br_taken, 1'b0);
`endif
        @(posedge clk); #1 idle_inputs(); #1;
        check("branch next-cycle EQ", br_taken, 1'b1);
        @(negedge clk);
        in_valid = 1; in_opcode = SUB; in_z = 0; stall = 1; br_cond = COND_EQ;
        #1 check("stalled sub no override", br_taken, 1'b1);
        stall = 0;
        #1;
`ifdef EX_FLAG_BYPASS_EN
        check("bypass sub z=0 EQ", br_taken, 1'b0);
`else
        check("held sub z=0 EQ", br_taken, 1'b1);
`endif
        @(posedge clk); #1 idle_inputs(); #1;
        check("after sub z=0 EQ", br_taken, 1'b0);

        // Randomized run against the reference model.
        @(negedge clk); idle_inputs(); rst = 1;
        @(posedge clk); model_clock();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 59) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_opcode  = 3'($urandom_range(0, 7));
            in_result  = 16'($urandom);
            in_z       = 1'($urandom); in_ov = 1'($urandom); in_n = 1'($urandom);
            in_wr_en   = 1'($urandom);
            in_dst     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 5) == 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            br_cond    = 3'($urandom_range(0, 7));
            #1;
            if (!rst) check($sformatf("rnd%0d br_taken", c), br_taken, model_br());
            @(posedge clk);
            model_clock();
            #1;
            check($sformatf("rnd%0d out_valid", c), out_valid, m_valid);
            check($sformatf("rnd%0d out_wr_en", c), out_wr_en, m_wr);
            check($sformatf("rnd%0d out_result", c), out_result, m_result);
            check($sformatf("rnd%0d out_dst", c), out_dst, m_dst);
            check($sformatf("rnd%0d flags", c), {flag_z, flag_ov, flag_n}, {m_z, m_ov, m_n});
            check($sformatf("rnd%0d ov_sticky", c), ov_sticky, m_sticky);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
